// File: rtl/banked_regfile_ctx_pkg.sv
// Shared definitions for the bexkat1 banked register file:
//   - clear-sequencer state encoding
//   - write_en mode encodings
//   - physical index helper mapping (architectural address, bank) to storage row
package banked_regfile_ctx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_BYTE = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_WORD = 2'b11;

    // Globals occupy rows [0, g); each bank owns b rows after them.
    // Addresses >= g are banked, and addr - g is the in-bank offset.
    function automatic int unsigned phys_idx(input int unsigned addr,
                                             input int unsigned bnk,
                                             input int unsigned g,
                                             input int unsigned b);
        if (addr < g) begin
            return addr;
        end
        return g + bnk * b + (addr - g);
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Hardware bank-clear sequencer: walks every register of a latched bank,
// one per cycle, zeroing it unless an external write to that bank stalls it.
// Ports:
//   clk_i, rst_i    clock, async active-high reset
//   clr_req_i       clear request, sampled only in IDLE
//   clr_bank_i      bank to clear
//   stall_i         external write targets the bank being cleared this cycle
//   clr_busy_o      registered, high while clearing
//   clr_done_o      registered, one-cycle completion pulse
//   lbank_o         latched bank under clear
//   clr_en_c        combinational, zero row clr_idx_c this cycle
//   clr_idx_c       combinational, physical row to zero
module regfile_clear_seq
    import banked_regfile_ctx_pkg::*;
#(
    parameter int unsigned NBANKS = 13,
    parameter int unsigned BANKW  = 4,
    parameter int unsigned G      = 8,
    parameter int unsigned B      = 8,
    parameter int unsigned IDXW   = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_req_i,
    input  logic [BANKW-1:0] clr_bank_i,
    input  logic             stall_i,
    output logic             clr_busy_o,
    output logic             clr_done_o,
    output logic [BANKW-1:0] lbank_o,
    output logic             clr_en_c,
    output logic [IDXW-1:0]  clr_idx_c
);

    localparam int unsigned CNTW = (B > 1) ? $clog2(B) : 1;

    clr_state_e       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [BANKW-1:0] lbank_q, lbank_d;
    logic             busy_q, done_q;

    // State, counter, latched bank and registered status flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lbank_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lbank_q <= lbank_d;
            busy_q  <= (state_d == ST_CLEAR);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Next-state and clear-enable
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lbank_d  = lbank_q;
        clr_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    if (32'(clr_bank_i) < NBANKS) begin
                        lbank_d = clr_bank_i;
                        cnt_d   = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CLEAR: begin
                // A colliding external write owns the bank this cycle
                if (!stall_i) begin
                    clr_en_c = 1'b1;
                    cnt_d    = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(B - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign clr_idx_c  = IDXW'(phys_idx(G + 32'(cnt_q), 32'(lbank_q), G, B));
    assign clr_busy_o = busy_q;
    assign clr_done_o = done_q;
    assign lbank_o    = lbank_q;

endmodule

// File: rtl/banked_regfile_ctx.sv
// Banked register file with global + per-bank registers, partial writes with
// sign/zero extension, write-to-read forwarding and a hardware bank clear.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   bank             current bank for reads and writes
//   read_addr        packed read addresses, port k at [k*WINP +: WINP]
//   data             packed read data (combinational), port k at [k*WIDTH +: WIDTH]
//   write_addr/data  write port
//   write_en         00 none, 01 byte, 10 half, 11 word
//   write_sext       sign-extend partial writes when set
//   clr_req/clr_bank bank clear request
//   clr_busy         clear in progress
//   clr_done         one-cycle clear completion pulse
module banked_regfile_ctx
    import banked_regfile_ctx_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned WINP   = 4,
    parameter int unsigned NBANKS = 13,
    parameter int unsigned BANKW  = 4,
    parameter int unsigned NREAD  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [BANKW-1:0]        bank,
    input  logic [NREAD*WINP-1:0]   read_addr,
    output logic [NREAD*WIDTH-1:0]  data,
    input  logic [WINP-1:0]         write_addr,
    input  logic [WIDTH-1:0]        write_data,
    input  logic [1:0]              write_en,
    input  logic                    write_sext,
    input  logic                    clr_req,
    input  logic [BANKW-1:0]        clr_bank,
    output logic                    clr_busy,
    output logic                    clr_done
);

    localparam int unsigned G     = 1 << (WINP - 1);
    localparam int unsigned B     = G;
    localparam int unsigned DEPTH = G + NBANKS * B;
    localparam int unsigned IDXW  = $clog2(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];

    logic             bank_ok;
    logic             wr_banked;
    logic             wr_valid;
    logic [IDXW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_val;
    logic             stall;
    logic             clr_en;
    logic [IDXW-1:0]  clr_idx;
    logic [BANKW-1:0] lbank;

    assign bank_ok   = 32'(bank) < NBANKS;
    assign wr_banked = write_addr[WINP-1];
    // Banked writes with an out-of-range bank are dropped
    assign wr_valid  = (write_en != WE_NONE) && (!wr_banked || bank_ok);
    assign wr_idx    = IDXW'(phys_idx(32'(write_addr), 32'(bank), G, B));
    assign stall     = clr_busy && wr_valid && wr_banked && (bank == lbank);

    // Partial-write extension
    always_comb begin
        wr_val = write_data;
        case (write_en)
            WE_BYTE: wr_val = {{(WIDTH-8){write_sext & write_data[7]}},  write_data[7:0]};
            WE_HALF: wr_val = {{(WIDTH-16){write_sext & write_data[15]}}, write_data[15:0]};
            default: wr_val = write_data;
        endcase
    end

    // Read ports with same-cycle forwarding of the extended write value
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [WINP-1:0]  ra;
        logic [IDXW-1:0]  ridx;
        logic [WIDTH-1:0] rval;

        assign ra   = read_addr[k*WINP +: WINP];
        assign ridx = IDXW'(phys_idx(32'(ra), 32'(bank), G, B));

        always_comb begin
            rval = regs_q[ridx];
            if (ra[WINP-1] && !bank_ok) begin
                rval = '0;
            end else if (wr_valid && (ridx == wr_idx)) begin
                rval = wr_val;
            end
        end

        assign data[k*WIDTH +: WIDTH] = rval;
    end

    // Storage; sequencer stalls on collision so both writes never hit one row
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                regs_q[clr_idx] <= '0;
            end
            if (wr_valid) begin
                regs_q[wr_idx] <= wr_val;
            end
        end
    end

    regfile_clear_seq #(
        .NBANKS (NBANKS),
        .BANKW  (BANKW),
        .G      (G),
        .B      (B),
        .IDXW   (IDXW)
    ) u_clr_seq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_req_i  (clr_req),
        .clr_bank_i (clr_bank),
        .stall_i    (stall),
        .clr_busy_o (clr_busy),
        .clr_done_o (clr_done),
        .lbank_o    (lbank),
        .clr_en_c   (clr_en),
        .clr_idx_c  (clr_idx)
    );

endmodule
